gpio_input_conditioner: RTL and testbench
=========================================

// Module: gpio_input_conditioner
// PURPOSE
//  Conditions raw board switches/buttons before they reach the SoC GPIO read path.
//  - Per-bit 2-flop synchroniser, then a debounce counter per bit.
//  - Latches rising/falling edge events and raises a level interrupt (wired to irq_5).
//  - Own iomem slave window for the debounced state, edge enables and pending flags.
//  - state_o drives the SoC's {gpio_button_i, gpio_switch_i} read mux.
// PARAMETERS
//  WIDTH      16       number of conditioned inputs ([7:0] switches, [15:8] buttons); max 32
//  DEB_CYCLES 50000    cycles an input must hold a new level before it is accepted; min 2
//  CNT_W      16       debounce counter width; must satisfy 2**CNT_W > DEB_CYCLES
//  BASE       8'h07    iomem_addr[31:24] value selecting this block
// PORTS
//  clk_i        in   1      system clock
//  resetn       in   1      synchronous, active-low reset
//  raw_i        in   WIDTH  asynchronous raw pad inputs
//  state_o      out  WIDTH  debounced level
//  irq_o        out  1      |(pending & (rise_en|fall_en)); level, not pulse
//  iomem_valid  in   1      bus request
//  iomem_ready  out  1      one-cycle acknowledge
//  iomem_wstrb  in   4      byte write strobes; 0 = read
//  iomem_addr   in   32     byte address
//  iomem_wdata  in   32     write data
//  iomem_rdata  out  32     read data, valid while iomem_ready=1
// BEHAVIOUR
//  Reset: sync flops, stable, counters, rise_en, fall_en, pending = 0;
//   state_o=0, irq_o=0, iomem_ready=0, iomem_rdata=0.
//  Sync: s1<=raw_i; s2<=s1. The output lags raw by 2 cycles before the debounce stage.
//  Debounce, per bit i:
//   - s2[i]==stable[i]: cnt[i]<=0.
//   - Otherwise, cnt[i]==DEB_CYCLES-1: stable[i]<=s2[i], cnt[i]<=0.
//   - Otherwise: cnt[i]<=cnt[i]+1.
//   - A glitch shorter than DEB_CYCLES restarts the count and never changes stable.
//   - Total latency raw->state_o = 2+DEB_CYCLES cycles.
//  Edges:
//   - rise[i] = stable changes 0->1; fall[i] = stable changes 1->0 (same cycle stable updates).
//   - pending[i] <= 1 when (rise[i]&rise_en[i]) | (fall[i]&fall_en[i]).
//   - Inputs high at reset release are seen as a rise after debounce. No irq results,
//     because the enables reset to 0.
//  Register map (addr[7:0]; addr[23:8] ignored):
//   - 0x00 STATE    RO  stable
//   - 0x04 RISE_EN  RW  reset 0
//   - 0x08 FALL_EN  RW  reset 0
//   - 0x0C PENDING  R/W1C
//   - 0x10 EVCNT    RO  (see CONFIGURATION)
//   - Other offsets read 0; writes to them are ignored.
//   - Bits >= WIDTH read 0.
//  Bus handshake:
//   - On iomem_valid && !iomem_ready && addr[31:24]==BASE: iomem_ready<=1 next cycle, for
//     exactly 1 cycle. The write is applied and iomem_rdata registered in that same edge.
//   - Back-to-back: a new access is accepted only after ready drops (minimum 2 cycles/access).
//   - Not selected: ready stays 0 and rdata is forced to 0, so the top-level OR/mux is safe.
//  Write rules:
//   - Byte lanes are honoured: wstrb[k] covers bits [8k+7:8k].
//   - W1C on PENDING clears the bits written as 1.
//   - W1C and a new event on the same bit in the same cycle: set wins, pending stays 1.
//   - Clearing an enable does not clear an existing pending bit.
//  Reset mid-debounce or mid-access: everything returns to reset values next edge;
//   ready is dropped and the interrupted access is not acknowledged.
// CONFIGURATION
//  GPIO_COND_EVCNT_EN defined:
//   - 16-bit EVCNT at 0x10 increments by 1 in any cycle where at least one pending bit
//     transitions 0->1 (multiple bits in one cycle count once).
//   - Saturates at 16'hFFFF.
//   - Any write to 0x10 clears it. When a clear coincides with an increment, the clear
//     wins and EVCNT becomes 0.
//  GPIO_COND_EVCNT_EN undefined: no counter logic; 0x10 reads 0; writes ignored.
// TESTING (DEB_CYCLES=4, WIDTH=16, BASE=8'h07)
//  1 Reset with raw_i=16'h0001 held -> state_o=16'h0001 exactly 6 cycles after resetn
//    rises; irq_o stays 0.
//  2 raw_i[3] pulses high for 3 cycles -> state_o[3] never changes; 4-cycle pulse
//    -> state_o[3]=1, 6 cycles after raw rises.
//  3 Write 0x07000004=32'h0000_0100, press raw_i[8] -> PENDING reads 32'h100, irq_o=1;
//    write 0x0700000C=32'h100 -> PENDING=0, irq_o=0.
//  4 W1C of bit 8 issued in the same cycle as a new rise on bit 8 -> PENDING bit 8 stays 1,
//    irq_o stays 1.
//  5 Read 0x07000000 -> ready high 1 cycle after valid, for 1 cycle, with rdata=state;
//    read 0x07000020 -> 0; access at 0x03000000 -> no ready, rdata=0.
//  6 With GPIO_COND_EVCNT_EN: 3 enabled edges -> EVCNT=3; write 0x07000010 -> 0.
//    Without the macro: 0x07000010 reads 0.

Source files
------------

// File: rtl/gpio_input_conditioner.sv
// gpio_input_conditioner: per-bit 2-flop synchroniser, debounce counter, edge
// event latching with a level interrupt, and an iomem slave register window.
// Optional event counter at offset 0x10 is built when GPIO_COND_EVCNT_EN is defined.
module gpio_input_conditioner #(
  parameter int          WIDTH      = 16,
  parameter int          DEB_CYCLES = 50000,
  parameter int          CNT_W      = 16,
  parameter logic [7:0]  BASE       = 8'h07
) (
  input  logic             clk_i,
  input  logic             resetn,
  input  logic [WIDTH-1:0] raw_i,
  output logic [WIDTH-1:0] state_o,
  output logic             irq_o,
  input  logic             iomem_valid,
  output logic             iomem_ready,
  input  logic [3:0]       iomem_wstrb,
  input  logic [31:0]      iomem_addr,
  input  logic [31:0]      iomem_wdata,
  output logic [31:0]      iomem_rdata
);

  logic [WIDTH-1:0] s1, s2, stable, stable_nxt;
  logic [WIDTH-1:0] rise_en, fall_en, pending, pending_nxt;
  logic [WIDTH-1:0] rise, fall, events, wmask, wdata_w, clr;
  logic [CNT_W-1:0] cnt     [WIDTH];
  logic [CNT_W-1:0] cnt_nxt [WIDTH];
  logic             sel, acc, wr;
  logic [7:0]       off;
  logic [31:0]      lane_mask, rd_val;
  logic             unused_bits;
`ifdef GPIO_COND_EVCNT_EN
  logic [15:0]      evcnt;
  logic             evcnt_inc, evcnt_clr;
`endif

  // Debounce: a bit accepts a new level once it has differed for DEB_CYCLES cycles.
  always_comb begin
    stable_nxt = stable;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      cnt_nxt[i] = '0;
      if (s2[i] != stable[i]) begin
        if (cnt[i] == CNT_W'(DEB_CYCLES - 1))
          stable_nxt[i] = s2[i];
        else
          cnt_nxt[i] = cnt[i] + CNT_W'(1);
      end
    end
  end

  assign rise   = stable_nxt & ~stable;
  assign fall   = ~stable_nxt & stable;
  assign events = (rise & rise_en) | (fall & fall_en);

  assign sel       = (iomem_addr[31:24] == BASE);
  assign acc       = iomem_valid && !iomem_ready && sel;
  assign wr        = acc && (|iomem_wstrb);
  assign off       = iomem_addr[7:0];
  assign lane_mask = {{8{iomem_wstrb[3]}}, {8{iomem_wstrb[2]}},
                      {8{iomem_wstrb[1]}}, {8{iomem_wstrb[0]}}};
  assign wmask     = lane_mask[WIDTH-1:0];
  assign wdata_w   = iomem_wdata[WIDTH-1:0];
  assign unused_bits = ^{iomem_addr[23:8], iomem_wdata, lane_mask};

  // Pending update: W1C first, then new events so a same-cycle event wins.
  always_comb begin
    clr = '0;
    if (wr && off == 8'h0C)
      clr = wdata_w & wmask;
    pending_nxt = (pending & ~clr) | events;
  end

  // Register read mux, sampled with pre-write values.
  always_comb begin
    rd_val = '0;
    case (off)
      8'h00: rd_val[WIDTH-1:0] = stable;
      8'h04: rd_val[WIDTH-1:0] = rise_en;
      8'h08: rd_val[WIDTH-1:0] = fall_en;
      8'h0C: rd_val[WIDTH-1:0] = pending;
`ifdef GPIO_COND_EVCNT_EN
      8'h10: rd_val[15:0]      = evcnt;
`endif
      default: rd_val = '0;
    endcase
  end

  // Synchroniser, debounced level and per-bit counters.
  always_ff @(posedge clk_i) begin
    if (!resetn) begin
      s1     <= '0;
      s2     <= '0;
      stable <= '0;
      for (int unsigned i = 0; i < WIDTH; i++) cnt[i] <= '0;
    end else begin
      s1     <= raw_i;
      s2     <= s1;
      stable <= stable_nxt;
      for (int unsigned i = 0; i < WIDTH; i++) cnt[i] <= cnt_nxt[i];
    end
  end

  // Control registers, pending flags and the one-cycle bus acknowledge.
  always_ff @(posedge clk_i) begin
    if (!resetn) begin
      rise_en     <= '0;
      fall_en     <= '0;
      pending     <= '0;
      iomem_ready <= 1'b0;
      iomem_rdata <= '0;
    end else begin
      pending <= pending_nxt;
      if (wr && off == 8'h04) rise_en <= (rise_en & ~wmask) | (wdata_w & wmask);
      if (wr && off == 8'h08) fall_en <= (fall_en & ~wmask) | (wdata_w & wmask);
      if (acc) begin
        iomem_ready <= 1'b1;
        iomem_rdata <= rd_val;
      end else begin
        iomem_ready <= 1'b0;
        iomem_rdata <= '0;
      end
    end
  end

`ifdef GPIO_COND_EVCNT_EN
  assign evcnt_inc = |(pending_nxt & ~pending);
  assign evcnt_clr = wr && (off == 8'h10);

  // Saturating event counter; a clear beats a coincident increment.
  always_ff @(posedge clk_i) begin
    if (!resetn)
      evcnt <= '0;
    else if (evcnt_clr)
      evcnt <= '0;
    else if (evcnt_inc && evcnt != 16'hFFFF)
      evcnt <= evcnt + 16'd1;
  end
`endif

  assign state_o = stable;
  assign irq_o   = |(pending & (rise_en | fall_en));

endmodule

// File: tb/tb_gpio_input_conditioner.sv
// Bench for gpio_input_conditioner: directed scenarios plus a randomized run,
// all checked against a behavioural model built from sample histories.
module tb_gpio_input_conditioner;
  localparam int         W    = 16;
  localparam int         DEB  = 4;
  localparam int         CW   = 4;
  localparam logic [7:0] BASE = 8'h07;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          resetn;
  logic [W-1:0]  raw;
  logic [W-1:0]  state_o;
  logic          irq_o;
  logic          valid;
  logic          ready;
  logic [3:0]    wstrb;
  logic [31:0]   addr, wdata, rdata;

  gpio_input_conditioner #(.WIDTH(W), .DEB_CYCLES(DEB), .CNT_W(CW), .BASE(BASE)) dut (
    .clk_i(clk), .resetn(resetn), .raw_i(raw), .state_o(state_o), .irq_o(irq_o),
    .iomem_valid(valid), .iomem_ready(ready), .iomem_wstrb(wstrb),
    .iomem_addr(addr), .iomem_wdata(wdata), .iomem_rdata(rdata)
  );

  int tests = 0;
  int fails = 0;

  // Reference model state
  logic [W-1:0]  m_stable, m_rise_en, m_fall_en, m_pending;
  logic [15:0]   m_evcnt;
  logic          m_ready;
  logic [31:0]   m_rdata;
  logic [W-1:0]  rawq[$];
  logic [W-1:0]  seenq[$];

  function automatic logic [31:0] m_read(input logic [7:0] off);
    logic [31:0] v;
    v = '0;
    case (off)
      8'h00: v[W-1:0] = m_stable;
      8'h04: v[W-1:0] = m_rise_en;
      8'h08: v[W-1:0] = m_fall_en;
      8'h0C: v[W-1:0] = m_pending;
`ifdef GPIO_COND_EVCNT_EN
      8'h10: v[15:0]  = m_evcnt;
`endif
      default: v = '0;
    endcase
    return v;
  endfunction

  function automatic logic m_irq();
    return |(m_pending & (m_rise_en | m_fall_en));
  endfunction

  // One clock edge: advance the model with the inputs present at the edge.
  task automatic tick();
    logic [W-1:0] seen, nstable, ev, wm, wd, npend;
    logic [31:0]  lm;
    logic         a, wr, same;
    logic [7:0]   off;
    @(posedge clk);
    if (!resetn) begin
      m_stable = '0; m_rise_en = '0; m_fall_en = '0; m_pending = '0;
      m_evcnt = '0; m_ready = 1'b0; m_rdata = '0;
      rawq.delete(); seenq.delete();
    end else begin
      rawq.push_back(raw);
      if (rawq.size() > 3) void'(rawq.pop_front());
      seen = (rawq.size() == 3) ? rawq[0] : '0;
      seenq.push_back(seen);
      if (seenq.size() > DEB) void'(seenq.pop_front());
      nstable = m_stable;
      if (seenq.size() == DEB) begin
        for (int i = 0; i < W; i++) begin
          same = 1'b1;
          for (int j = 1; j < DEB; j++)
            if (seenq[j][i] != seenq[0][i]) same = 1'b0;
          if (same && seenq[0][i] != m_stable[i]) nstable[i] = seenq[0][i];
        end
      end
      ev  = (nstable & ~m_stable & m_rise_en) | (~nstable & m_stable & m_fall_en);
      off = addr[7:0];
      a   = valid && !m_ready && (addr[31:24] == BASE);
      wr  = a && (wstrb != 4'b0);
      lm  = {{8{wstrb[3]}}, {8{wstrb[2]}}, {8{wstrb[1]}}, {8{wstrb[0]}}};
      wm  = lm[W-1:0];
      wd  = wdata[W-1:0];
      npend = m_pending;
      if (wr && off == 8'h0C) npend = npend & ~(wd & wm);
      npend = npend | ev;
      m_rdata = a ? m_read(off) : 32'h0;
      m_ready = a;
`ifdef GPIO_COND_EVCNT_EN
      if (wr && off == 8'h10) m_evcnt = '0;
      else if ((npend & ~m_pending) != '0 && m_evcnt != 16'hFFFF) m_evcnt = m_evcnt + 16'd1;
`endif
      if (wr && off == 8'h04) m_rise_en = (m_rise_en & ~wm) | (wd & wm);
      if (wr && off == 8'h08) m_fall_en = (m_fall_en & ~wm) | (wd & wm);
      m_pending = npend;
      m_stable  = nstable;
    end
    #1;
  endtask

  task automatic bus_acc(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                         output logic rdy, output logic [31:0] rd);
    valid = 1'b1; addr = a; wdata = d; wstrb = s;
    tick();
    rdy = ready; rd = rdata;
    valid = 1'b0; wstrb = 4'b0;
    tick();
  endtask

  task automatic wait_bit(input int b, input logic v, output int n);
    n = 0;
    while (state_o[b] !== v && n < 30) begin
      tick();
      n++;
    end
  endtask

  task automatic test_reset();
    resetn = 1'b0; raw = 16'h0001; valid = 1'b0; wstrb = '0; addr = '0; wdata = '0;
    repeat (3) tick();
    tests++; if (state_o !== 16'h0) begin fails++; $display("FAIL reset_state: got %h want 0000", state_o); end
    tests++; if (irq_o !== 1'b0) begin fails++; $display("FAIL reset_irq: got %b want 0", irq_o); end
    tests++; if (ready !== 1'b0) begin fails++; $display("FAIL reset_ready: got %b want 0", ready); end
    tests++; if (rdata !== 32'h0) begin fails++; $display("FAIL reset_rdata: got %h want 0", rdata); end
    resetn = 1'b1;
    repeat (5) tick();
    tests++; if (state_o !== 16'h0) begin fails++; $display("FAIL reset_lat5: got %h want 0000", state_o); end
    tick();
    tests++; if (state_o !== 16'h0001) begin fails++; $display("FAIL reset_lat6: got %h want 0001", state_o); end
    tests++; if (irq_o !== 1'b0) begin fails++; $display("FAIL reset_rise_irq: got %b want 0", irq_o); end
  endtask

  task automatic test_glitch();
    logic hi;
    int   n;
    raw[3] = 1'b1;
    repeat (3) tick();
    raw[3] = 1'b0;
    hi = 1'b0;
    repeat (10) begin tick(); if (state_o[3]) hi = 1'b1; end
    tests++; if (hi !== 1'b0) begin fails++; $display("FAIL glitch3: state_o[3] rose, want never"); end
    raw[3] = 1'b1;
    n = 0;
    while (state_o[3] !== 1'b1 && n < 20) begin
      tick();
      n++;
      if (n == 4) raw[3] = 1'b0;
    end
    tests++; if (n != 6) begin fails++; $display("FAIL pulse4_latency: got %0d cycles want 6", n); end
    repeat (12) tick();
    tests++; if (state_o !== m_stable) begin fails++; $display("FAIL glitch_model: got %h want %h", state_o, m_stable); end
  endtask

  task automatic test_irq();
    logic rdy; logic [31:0] rd; int n;
    bus_acc(32'h0700_0004, 32'h0000_0100, 4'hF, rdy, rd);
    tests++; if (rdy !== 1'b1) begin fails++; $display("FAIL irq_en_ack: got %b want 1", rdy); end
    raw[8] = 1'b1;
    wait_bit(8, 1'b1, n);
    tests++; if (n >= 30) begin fails++; $display("FAIL irq_press_timeout: waited %0d want <30", n); end
    tests++; if (irq_o !== 1'b1) begin fails++; $display("FAIL irq_set: got %b want 1", irq_o); end
    bus_acc(32'h0700_000C, 32'h0, 4'h0, rdy, rd);
    tests++; if (rd !== 32'h100) begin fails++; $display("FAIL pending_read: got %h want 00000100", rd); end
    bus_acc(32'h0700_000C, 32'h100, 4'hF, rdy, rd);
    bus_acc(32'h0700_000C, 32'h0, 4'h0, rdy, rd);
    tests++; if (rd !== 32'h0) begin fails++; $display("FAIL pending_w1c: got %h want 0", rd); end
    tests++; if (irq_o !== 1'b0) begin fails++; $display("FAIL irq_clear: got %b want 0", irq_o); end
  endtask

  task automatic test_w1c_collision();
    logic rdy; logic [31:0] rd; int n;
    bus_acc(32'h0700_0008, 32'h100, 4'hF, rdy, rd);
    raw[8] = 1'b0;
    wait_bit(8, 1'b0, n);
    tests++; if (irq_o !== 1'b1) begin fails++; $display("FAIL fall_irq: got %b want 1", irq_o); end
    raw[8] = 1'b1;
    repeat (5) tick();
    valid = 1'b1; addr = 32'h0700_000C; wdata = 32'h100; wstrb = 4'hF;
    tick();
    tests++; if (state_o[8] !== 1'b1 || ready !== 1'b1) begin
      fails++; $display("FAIL collide_align: state8=%b ready=%b want 1 1", state_o[8], ready); end
    valid = 1'b0; wstrb = 4'h0;
    tick();
    tests++; if (irq_o !== 1'b1) begin fails++; $display("FAIL collide_irq: got %b want 1", irq_o); end
    bus_acc(32'h0700_000C, 32'h0, 4'h0, rdy, rd);
    tests++; if (rd !== 32'h100) begin fails++; $display("FAIL collide_pending: got %h want 00000100", rd); end
    bus_acc(32'h0700_0004, 32'h0, 4'hF, rdy, rd);
    bus_acc(32'h0700_0008, 32'h0, 4'hF, rdy, rd);
    bus_acc(32'h0700_000C, 32'h0, 4'h0, rdy, rd);
    tests++; if (rd !== 32'h100) begin fails++; $display("FAIL en_clear_keeps_pending: got %h want 00000100", rd); end
    tests++; if (irq_o !== 1'b0) begin fails++; $display("FAIL irq_masked: got %b want 0", irq_o); end
    bus_acc(32'h0700_000C, 32'hFFFF, 4'hF, rdy, rd);
  endtask

  task automatic test_bus();
    logic rdy; logic [31:0] rd; logic [3:0] pat;
    valid = 1'b1; addr = 32'h0700_0000; wstrb = 4'h0;
    for (int k = 0; k < 4; k++) begin tick(); pat[k] = ready; if (k == 0) rd = rdata; end
    valid = 1'b0;
    tick();
    tests++; if (pat !== 4'b0101) begin fails++; $display("FAIL b2b_ready: got %b want 0101", pat); end
    tests++; if (rd !== {16'h0, state_o}) begin fails++; $display("FAIL state_read: got %h want %h", rd, {16'h0, state_o}); end
    bus_acc(32'h0700_0020, 32'h0, 4'h0, rdy, rd);
    tests++; if (rdy !== 1'b1 || rd !== 32'h0) begin fails++; $display("FAIL hole_read: rdy=%b rd=%h want 1 0", rdy, rd); end
    bus_acc(32'h0700_0004, 32'hFFFF_FFFF, 4'b0010, rdy, rd);
    bus_acc(32'h0712_3404, 32'h0, 4'h0, rdy, rd);
    tests++; if (rd !== 32'h0000_FF00) begin fails++; $display("FAIL byte_lane: got %h want 0000ff00", rd); end
    bus_acc(32'h0700_0004, 32'h0, 4'hF, rdy, rd);
    bus_acc(32'h0300_0004, 32'hFFFF, 4'hF, rdy, rd);
    tests++; if (rdy !== 1'b0 || rd !== 32'h0) begin fails++; $display("FAIL unselected: rdy=%b rd=%h want 0 0", rdy, rd); end
    bus_acc(32'h0700_0004, 32'h0, 4'h0, rdy, rd);
    tests++; if (rd !== 32'h0) begin fails++; $display("FAIL unselected_write: got %h want 0", rd); end
  endtask

  task automatic test_evcnt();
    logic rdy; logic [31:0] rd; logic [31:0] want; int n;
    bus_acc(32'h0700_000C, 32'hFFFF, 4'hF, rdy, rd);
    bus_acc(32'h0700_0010, 32'h1, 4'hF, rdy, rd);
    bus_acc(32'h0700_0004, 32'h0070, 4'hF, rdy, rd);
    for (int b = 4; b < 7; b++) begin
      raw[b] = 1'b1;
      wait_bit(b, 1'b1, n);
    end
`ifdef GPIO_COND_EVCNT_EN
    want = 32'd3;
`else
    want = 32'd0;
`endif
    bus_acc(32'h0700_0010, 32'h0, 4'h0, rdy, rd);
    tests++; if (rd !== want) begin fails++; $display("FAIL evcnt_count: got %h want %h", rd, want); end
    bus_acc(32'h0700_0010, 32'h0, 4'h1, rdy, rd);
    bus_acc(32'h0700_0010, 32'h0, 4'h0, rdy, rd);
    tests++; if (rd !== 32'h0) begin fails++; $display("FAIL evcnt_clear: got %h want 0", rd); end
  endtask

  task automatic test_reset_mid();
    valid = 1'b1; addr = 32'h0700_0000; wstrb = 4'h0; raw = '0;
    tick();
    resetn = 1'b0;
    tick();
    tests++; if (ready !== 1'b0 || state_o !== '0 || irq_o !== 1'b0) begin
      fails++; $display("FAIL reset_mid: ready=%b state=%h irq=%b want 0 0 0", ready, state_o, irq_o); end
    valid = 1'b0;
    tick();
    resetn = 1'b1;
    tick();
  endtask

  task automatic test_random();
    int bad;
    bad = 0;
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 7) == 0) raw[$urandom_range(0, W-1)] ^= 1'b1;
      valid = ($urandom_range(0, 2) == 0);
      addr  = {($urandom_range(0, 3) == 0) ? 8'h03 : BASE, 16'($urandom),
               8'($urandom_range(0, 8) * 4)};
      wstrb = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom);
      wdata = $urandom;
      resetn = ($urandom_range(0, 499) != 0);
      tick();
      tests++;
      if ({state_o, irq_o, ready, rdata} !== {m_stable, m_irq(), m_ready, m_rdata}) begin
        fails++;
        if (bad < 10)
          $display("FAIL random_c%0d: state=%h irq=%b rdy=%b rd=%h want %h %b %b %h",
                   c, state_o, irq_o, ready, rdata, m_stable, m_irq(), m_ready, m_rdata);
        bad++;
      end
    end
    valid = 1'b0; resetn = 1'b1;
  endtask

  initial begin
    test_reset();
    test_glitch();
    test_irq();
    test_w1c_collision();
    test_bus();
    test_evcnt();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
